// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and branch direction counter.
// Includes the saturating update rule for the 2-bit counter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bpred_ctr_t;

  function automatic bpred_ctr_t ctr_next(
    input bpred_ctr_t c,
    input logic       taken
  );
    bpred_ctr_t n;
    n = c;
    unique case (c)
      STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  n = taken ? STRONG_T : WEAK_T;
      default:   n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_target_buffer_stats.sv
// Saturating event counters for the BTB (lookups, updates, mispredicts).
// Ports: CLK/RST, three increment strobes, three STAT_W counts.
module btb_stats
  import cpu_types_pkg::*;
#(
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              inc_lookup,
  input  logic              inc_update,
  input  logic              inc_mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  logic [STAT_W-1:0] lookups_q, lookups_d;
  logic [STAT_W-1:0] updates_q, updates_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    lookups_d = lookups_q;
    updates_d = updates_q;
    mispred_d = mispred_q;
    if (inc_lookup && (lookups_q != '1)) begin
      lookups_d = lookups_q + 1'b1;
    end
    if (inc_update && (updates_q != '1)) begin
      updates_d = updates_q + 1'b1;
    end
    if (inc_mispredict && (mispred_q != '1)) begin
      mispred_d = mispred_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lookups_q <= '0;
      updates_q <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      updates_q <= updates_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_updates     = updates_q;
  assign stat_mispredicts = mispred_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Tagged BTB with 2-bit direction counters; async lookup, sync update.
// Ports: rd_* lookup, upd_* resolved-branch writeback, flush, stat_*.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int STAT_W  = 32,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  word_t             rd_pc,
  output logic              rd_hit,
  output logic              rd_take,
  output word_t             rd_target,
  output logic [IDX_W-1:0]  rd_index,
  input  logic              upd_valid,
  input  word_t             upd_pc,
  input  logic              upd_taken,
  input  word_t             upd_target,
  input  logic              upd_mispredict,
  input  logic              flush,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int TAG_W = 30 - IDX_W;

  if ((ENTRIES < 2) || (ENTRIES > 256) ||
      ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("ENTRIES must be a power of two in 2..256");
  end

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            target;
    bpred_ctr_t       ctr;
  } btb_entry_t;

  localparam btb_entry_t RST_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    WEAK_NT
  };

  btb_entry_t tbl_q [ENTRIES];
  btb_entry_t tbl_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       rd_ent;
  btb_entry_t       upd_ent;
  logic             upd_hit;
  logic             unused_pc_lsbs;

  assign rd_idx  = rd_pc[IDX_W+1:2];
  assign rd_tag  = rd_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Byte offset within the word plays no part in indexing.
  assign unused_pc_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

  assign rd_ent  = tbl_q[rd_idx];
  assign upd_ent = tbl_q[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

  assign rd_hit    = rd_ent.valid && (rd_ent.tag == rd_tag);
  assign rd_take   = rd_hit && rd_ent.ctr[1];
  assign rd_target = rd_hit ? rd_ent.target : '0;
  assign rd_index  = rd_idx;

  // Flush wins over a same-cycle update; not-taken misses never allocate.
  always_comb begin
    tbl_d = tbl_q;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_d[i].valid = 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        tbl_d[upd_idx].ctr = ctr_next(upd_ent.ctr, upd_taken);
        if (upd_taken) begin
          tbl_d[upd_idx].target = upd_target;
        end
      end else if (upd_taken) begin
        tbl_d[upd_idx] = '{
          valid:  1'b1,
          tag:    upd_tag,
          target: upd_target,
          ctr:    WEAK_T
        };
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (RST) begin
        tbl_q[i] <= RST_ENTRY;
      end else begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  btb_stats #(
    .STAT_W (STAT_W)
  ) u_stats (
    .CLK              (CLK),
    .RST              (RST),
    .inc_lookup       (rd_hit),
    .inc_update       (upd_valid),
    .inc_mispredict   (upd_valid && upd_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed cases plus random traffic
// checked against an array-based reference model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int STAT_W  = 4;
  localparam int IDX_W   = 4;
  localparam int SMAX    = (1 << STAT_W) - 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic [31:0]       rd_pc;
  logic              rd_hit;
  logic              rd_take;
  logic [31:0]       rd_target;
  logic [IDX_W-1:0]  rd_index;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_mispredict;
  logic              flush;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  always #5 CLK = ~CLK;

  branch_target_buffer #(
    .ENTRIES (ENTRIES),
    .STAT_W  (STAT_W)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .rd_pc            (rd_pc),
    .rd_hit           (rd_hit),
    .rd_take          (rd_take),
    .rd_target        (rd_target),
    .rd_index         (rd_index),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .flush            (flush),
    .stat_lookups     (stat_lookups),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  int total = 0;
  int bad   = 0;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_look, m_upd, m_mis;
  bit          m_known = 1'b0;

  logic        obs_hit, obs_take;
  logic [31:0] obs_tgt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic int sat(input int v);
    return (v < SMAX) ? v + 1 : v;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic rst, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg,
                      input logic um, input logic fl);
    bit h;
    int ri, ui;
    RST = rst; rd_pc = rpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg; upd_mispredict = um; flush = fl;
    #1;
    obs_hit = rd_hit; obs_take = rd_take; obs_tgt = rd_target;
    ri = idx_of(rpc);
    h  = m_hit(rpc);
    if (m_known) begin
      chk("hit", rd_hit, h);
      chk("take", rd_take, h && (m_ctr[ri] >= 2));
      chk("target", rd_target, h ? m_tgt[ri] : 32'h0);
      chk("index", rd_index, ri);
      chk("st_look", stat_lookups, m_look);
      chk("st_upd", stat_updates, m_upd);
      chk("st_mis", stat_mispredicts, m_mis);
    end
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_look = 0; m_upd = 0; m_mis = 0;
      m_known = 1'b1;
    end else begin
      if (h) m_look = sat(m_look);
      if (uv) m_upd = sat(m_upd);
      if (uv && um) m_mis = sat(m_mis);
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (uv) begin
        ui = idx_of(upc);
        if (m_hit(upc)) begin
          if (ut) begin
            m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            m_tgt[ui] = utg;
          end else begin
            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          end
        end else if (ut) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = tag_of(upc);
          m_tgt[ui]   = utg;
          m_ctr[ui]   = 2;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t,
                     input logic [31:0] tg, input logic mis);
    step(1'b0, 32'h0, 1'b1, pc, t, tg, mis, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    logic [31:0] ix;
    logic [31:0] lo;
    case ($urandom_range(0, 3))
      0:       t = 32'h0;
      1:       t = 32'h1;
      2:       t = 32'h2;
      default: t = 32'h03ff_ffff;
    endcase
    ix = 32'($urandom_range(0, ENTRIES - 1));
    lo = 32'($urandom_range(0, 3));
    return (t << (IDX_W + 2)) | (ix << 2) | lo;
  endfunction

  initial begin
    RST = 1'b0; rd_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    flush = 1'b0;
    @(negedge CLK);

    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    look(32'h40);
    chk("rst_hit", obs_hit, 1'b0);
    chk("rst_take", obs_take, 1'b0);
    chk("rst_tgt", obs_tgt, 32'h0);
    chk("rst_look", stat_lookups, 0);
    chk("rst_upd", stat_updates, 0);
    chk("rst_mis", stat_mispredicts, 0);

    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look(32'h40);
    chk("alloc_hit", obs_hit, 1'b1);
    chk("alloc_take", obs_take, 1'b1);
    chk("alloc_tgt", obs_tgt, 32'h100);

    upd(32'h40, 1'b0, 32'h999, 1'b0);
    look(32'h40);
    chk("wnt_hit", obs_hit, 1'b1);
    chk("wnt_take", obs_take, 1'b0);
    chk("wnt_tgt", obs_tgt, 32'h100);

    repeat (3) upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    chk("sat_take", obs_take, 1'b1);

    upd(32'h80, 1'b1, 32'h200, 1'b0);
    look(32'h40);
    chk("alias_old", obs_hit, 1'b0);
    look(32'h80);
    chk("alias_hit", obs_hit, 1'b1);
    chk("alias_tgt", obs_tgt, 32'h200);

    upd(32'h44, 1'b0, 32'h300, 1'b0);
    look(32'h44);
    chk("nt_miss", obs_hit, 1'b0);

    step(1'b0, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("byp_take", obs_take, 1'b1);
    look(32'h80);
    chk("post_take", obs_take, 1'b0);
    chk("post_hit", obs_hit, 1'b1);

    step(1'b0, 32'h0, 1'b1, 32'h48, 1'b1, 32'h400, 1'b0, 1'b1);
    look(32'h48);
    chk("fl_48", obs_hit, 1'b0);
    look(32'h80);
    chk("fl_80", obs_hit, 1'b0);
    chk("fl_upd", stat_updates, 10);
    chk("fl_look", stat_lookups, 6);

    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) upd(rand_pc(), 1'($urandom_range(0, 1)), $urandom, 1'b1);
    chk("sat_mis", stat_mispredicts, 15);
    chk("sat_upd", stat_updates, 15);
    step(1'b1, 32'h0, 1'b1, 32'h40, 1'b1, 32'h0, 1'b1, 1'b0);
    chk("rst_look2", stat_lookups, 0);
    chk("rst_upd2", stat_updates, 0);
    chk("rst_mis2", stat_mispredicts, 0);

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 199) == 0), rand_pc(),
           1'($urandom_range(0, 1)), rand_pc(),
           1'($urandom_range(0, 2) != 0), $urandom,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised, tagged branch target buffer with per-entry 2-bit saturating direction counters, for the fetch stage of the pipelined MIPS core. Supersedes the fixed 4-entry, untagged, 1-bit predictor. Fetch performs a combinational lookup on the current fetch address. The memory stage writes back each resolved branch outcome. A flush input and saturating statistics counters support context switches and performance measurement.

## Interface
- ENTRIES, 16, number of table entries; power of two, 2..256; IDX_W = $clog2(ENTRIES)
- STAT_W, 32, width of each statistics counter
- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  reset; synchronous and active-high, one clock, reset is synchronous active-high
- rd_pc  in  32  fetch address to look up
- rd_hit  out  1  valid entry with matching tag
- rd_take  out  1  predict taken (rd_hit & counter[1])
- rd_target  out  32  stored target; 0 when !rd_hit
- rd_index  out  IDX_W  rd_pc[IDX_W+1:2], carried down the pipe
- upd_valid  in  1  a branch resolved this cycle
- upd_pc  in  32  address of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual branch target
- upd_mispredict  in  1  pipeline flushed for this branch (statistics only)
- flush  in  1  invalidate all entries
- stat_lookups  out  STAT_W  count of rd_hit cycles
- stat_updates  out  STAT_W  count of upd_valid cycles
- stat_mispredicts  out  STAT_W  count of upd_valid & upd_mispredict cycles

## Operation
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Each entry holds valid, tag, target (32 bits) and ctr (2 bits).
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup is purely combinational from rd_pc and the table state.
- Update, registered at the edge when upd_valid=1:
  - Hit with upd_taken=1: ctr increments, saturating at 11; target <= upd_target.
  - Hit with upd_taken=0: ctr decrements, saturating at 00; target unchanged.
  - Miss with upd_taken=1: allocate the entry, overwriting any previous occupant. valid=1, tag and target written, ctr=10.
  - Miss with upd_taken=0: no change.
- flush=1: all valid bits <= 0 at the edge. Tags, targets and counters are don't-care. flush takes priority over a same-cycle update. Statistics are not cleared by flush.
- Statistics counters saturate at all-ones and never wrap.

## Timing
- Lookup latency 0 cycles. An update or flush is visible to a lookup from the next cycle on.
- No write-to-read bypass: a same-cycle update and lookup at the same index return the pre-update contents.
- Reset, taking effect at the edge where RST=1:
  - All valid bits <= 0 and all ctr <= 01.
  - All statistics <= 0.
  - After reset, outputs are rd_hit=0, rd_take=0, rd_target=0.
- RST asserted mid-stream overrides update and flush in that cycle. Statistics do not count the reset cycle.
- Statistics increment at the edge following the qualifying cycle.

## Structure
- In cpu_types_pkg:
  - Add enum bpred_ctr_t {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T} (2 bits).
  - Add the btb_entry_t struct {valid, tag, word_t target, bpred_ctr_t ctr}. The tag width is set by the ENTRIES parameter, so btb_entry_t is parametrised on it or declared locally to the module.
  - Reuse word_t for all 32-bit addresses.
- The table is an array of btb_entry_t in flops, not inferred RAM, because lookup is asynchronous.
- Sub-module: btb_stats, three saturating STAT_W counters with synchronous reset.
- Elaboration-time assertion: ENTRIES is a power of two and lies in range.

## Test plan
- Reset, then rd_pc=0x0000_0040 -> rd_hit=0, rd_take=0, rd_target=0; all stat_* = 0.
- Update pc=0x40, taken, target=0x100 -> next cycle, rd_pc=0x40 gives hit=1, take=1, target=0x100 (ctr=10). Update not-taken once -> take=0 (ctr=01). Update taken twice more -> ctr=11.
- Aliasing with ENTRIES=16: allocate 0x40 (target 0x100), then allocate 0x80 (same index 0, different tag, target 0x200) -> lookup 0x40 misses; lookup 0x80 hits with target 0x200.
- Not-taken miss at 0x44 -> entry stays invalid and rd_hit=0. Same-cycle lookup and update at 0x40 -> lookup returns the old value.
- flush and an update of 0x48 in the same cycle -> all lookups miss next cycle, 0x48 included; statistics are retained.
- STAT_W=4 bench with 20 mispredicting updates -> stat_mispredicts holds at 15 and stat_updates holds at 15. RST mid-run -> all statistics read 0 next cycle.
